// File: rtl/tx_stream_adapter.sv
// -----------------------------------------------------------------------------
// tx_stream_adapter
//
// Purpose:
//   Turns one tx request (byte length + tag) and its 32-bit tx data words
//   into a framed AXI4-Stream (tkeep/tlast) carrying exactly `length` bytes.
//   When the frame is done it returns a tx response that echoes the tag and
//   the number of bytes forwarded. Only one transfer is in flight at a time.
//   A new request is refused until the previous response has been taken.
//
// Parameters:
//   MAX_LEN_BYTES : largest legal request length. A longer request is still
//                   transferred, but it sets the sticky detect_fault flag.
//   DATA_W        : payload width. Must be 32; any other value fails
//                   elaboration.
//
// Optional build macro:
//   TX_STREAM_ADAPTER_STATS_EN : adds the stat_frames and stat_stall_cycles
//                                counters and their ports.
//
// Ports:
//   ap_clk, ap_rst_n        clock, asynchronous active-low reset
//   s_axis_tx_req_*         request stream: [31:0] length, [63:32] tag
//   s_axis_tx_data_*        payload words, byte 0 in [7:0]
//   m_axis_tx_resp_*        response stream: [31:0] bytes forwarded,
//                           [63:32] tag echo
//   m_axis_out_*            framed payload with tkeep/tlast
//   detect_fault            sticky flag for an over-length request
//   stat_frames             (stats build only) response handshake count
//   stat_stall_cycles       (stats build only) output backpressure cycles
// -----------------------------------------------------------------------------
module tx_stream_adapter #(
   parameter logic [31:0] MAX_LEN_BYTES = 32'h0100_0000,
   parameter int          DATA_W        = 32
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic [63:0]       s_axis_tx_req_tdata,
   input  logic              s_axis_tx_req_tvalid,
   output logic              s_axis_tx_req_tready,
   input  logic [DATA_W-1:0] s_axis_tx_data_tdata,
   input  logic              s_axis_tx_data_tvalid,
   output logic              s_axis_tx_data_tready,
   output logic [63:0]       m_axis_tx_resp_tdata,
   output logic              m_axis_tx_resp_tvalid,
   input  logic              m_axis_tx_resp_tready,
   output logic [DATA_W-1:0] m_axis_out_tdata,
   output logic [3:0]        m_axis_out_tkeep,
   output logic              m_axis_out_tlast,
   output logic              m_axis_out_tvalid,
   input  logic              m_axis_out_tready,
`ifdef TX_STREAM_ADAPTER_STATS_EN
   output logic [31:0]       stat_frames,
   output logic [31:0]       stat_stall_cycles,
`endif
   output logic              detect_fault
);

   // The byte lane arithmetic below assumes four lanes.
   generate
      if (DATA_W != 32) begin : g_bad_data_w
         $error("tx_stream_adapter: DATA_W must be 32");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Byte enables for the beat that starts with `rem` bytes left.
   function automatic logic [3:0] keep_for_rem(input logic [31:0] rem);
      logic [3:0] keep;
      case (rem)
         32'd0:   keep = 4'b0000;
         32'd1:   keep = 4'b0001;
         32'd2:   keep = 4'b0011;
         32'd3:   keep = 4'b0111;
         default: keep = 4'b1111;
      endcase
      return keep;
   endfunction

   // Number of valid bytes in the beat that starts with `rem` bytes left.
   function automatic logic [31:0] beat_bytes(input logic [31:0] rem);
      logic [31:0] n;
      if (rem >= 32'd4) begin
         n = 32'd4;
      end else begin
         n = rem;
      end
      return n;
   endfunction

   // Reset synchronizer: assertion is immediate, release is aligned to ap_clk.
   logic [1:0]  rst_sync_r;
   logic        rst_int_n_s;

   state_t      state_r;
   state_t      state_next_s;
   logic        req_ready_r;
   logic [31:0] tag_r;
   logic [31:0] rem_r;
   logic [31:0] cnt_r;
   logic        resp_valid_r;
   logic [63:0] resp_data_r;
   logic        detect_fault_r;

   logic [31:0] req_len_s;
   logic [31:0] req_tag_s;
   logic        req_fire_s;
   logic        beat_fire_s;
   logic        last_s;
   logic        resp_fire_s;

   // Two-flop reset release synchronizer.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         rst_sync_r <= 2'b00;
      end else begin
         rst_sync_r <= {rst_sync_r[0], 1'b1};
      end
   end

   assign rst_int_n_s = rst_sync_r[1];

   assign req_len_s   = s_axis_tx_req_tdata[31:0];
   assign req_tag_s   = s_axis_tx_req_tdata[63:32];
   assign req_fire_s  = s_axis_tx_req_tvalid & req_ready_r;
   assign beat_fire_s = (state_r == ST_DATA) & s_axis_tx_data_tvalid & m_axis_out_tready;
   // rem_r counts the bytes still owed, so a beat that covers four or fewer ends the frame.
   assign last_s      = (rem_r <= 32'd4);
   assign resp_fire_s = resp_valid_r & m_axis_tx_resp_tready;

   // FSM state register.
   always_ff @(posedge ap_clk or negedge rst_int_n_s) begin
      if (!rst_int_n_s) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state decode.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (req_fire_s) begin
               if (req_len_s == 32'd0) begin
                  state_next_s = ST_RESP;
               end else begin
                  state_next_s = ST_DATA;
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (beat_fire_s && last_s) begin
               state_next_s = ST_RESP;
            end else begin
               state_next_s = ST_DATA;
            end
         end
         ST_RESP: begin
            if (resp_fire_s) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_RESP;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // FSM outputs: the payload passes straight through while a frame is open.
   always_comb begin
      m_axis_out_tvalid     = 1'b0;
      m_axis_out_tdata      = '0;
      m_axis_out_tkeep      = 4'b0000;
      m_axis_out_tlast      = 1'b0;
      s_axis_tx_data_tready = 1'b0;
      case (state_r)
         ST_DATA: begin
            m_axis_out_tvalid     = s_axis_tx_data_tvalid;
            m_axis_out_tdata      = s_axis_tx_data_tdata;
            m_axis_out_tkeep      = keep_for_rem(rem_r);
            m_axis_out_tlast      = last_s;
            s_axis_tx_data_tready = m_axis_out_tready;
         end
         ST_IDLE, ST_RESP: begin
            m_axis_out_tvalid     = 1'b0;
            s_axis_tx_data_tready = 1'b0;
         end
         default: begin
            m_axis_out_tvalid     = 1'b0;
            s_axis_tx_data_tready = 1'b0;
         end
      endcase
   end

   // Request ready is registered: it stays low in reset and rises once the FSM rests in IDLE.
   always_ff @(posedge ap_clk or negedge rst_int_n_s) begin
      if (!rst_int_n_s) begin
         req_ready_r <= 1'b0;
      end else begin
         req_ready_r <= (state_next_s == ST_IDLE);
      end
   end

   // Per-transfer context: the tag, the bytes still owed, and the bytes forwarded.
   always_ff @(posedge ap_clk or negedge rst_int_n_s) begin
      if (!rst_int_n_s) begin
         tag_r <= 32'd0;
         rem_r <= 32'd0;
         cnt_r <= 32'd0;
      end else if (req_fire_s) begin
         tag_r <= req_tag_s;
         rem_r <= req_len_s;
         cnt_r <= 32'd0;
      end else if (beat_fire_s) begin
         rem_r <= (rem_r >= 32'd4) ? (rem_r - 32'd4) : 32'd0;
         cnt_r <= cnt_r + beat_bytes(rem_r);
      end else begin
         tag_r <= tag_r;
         rem_r <= rem_r;
         cnt_r <= cnt_r;
      end
   end

   // Response register: loaded as the FSM enters RESP and held until it is accepted.
   always_ff @(posedge ap_clk or negedge rst_int_n_s) begin
      if (!rst_int_n_s) begin
         resp_valid_r <= 1'b0;
         resp_data_r  <= 64'd0;
      end else if (req_fire_s && (req_len_s == 32'd0)) begin
         resp_valid_r <= 1'b1;
         resp_data_r  <= {req_tag_s, 32'd0};
      end else if (beat_fire_s && last_s) begin
         resp_valid_r <= 1'b1;
         resp_data_r  <= {tag_r, cnt_r + beat_bytes(rem_r)};
      end else if (resp_fire_s) begin
         resp_valid_r <= 1'b0;
         resp_data_r  <= resp_data_r;
      end else begin
         resp_valid_r <= resp_valid_r;
         resp_data_r  <= resp_data_r;
      end
   end

   // Sticky over-length flag; only reset clears it.
   always_ff @(posedge ap_clk or negedge rst_int_n_s) begin
      if (!rst_int_n_s) begin
         detect_fault_r <= 1'b0;
      end else if (req_fire_s && (req_len_s > MAX_LEN_BYTES)) begin
         detect_fault_r <= 1'b1;
      end else begin
         detect_fault_r <= detect_fault_r;
      end
   end

   assign s_axis_tx_req_tready  = req_ready_r;
   assign m_axis_tx_resp_tvalid = resp_valid_r;
   assign m_axis_tx_resp_tdata  = resp_data_r;
   assign detect_fault          = detect_fault_r;

`ifdef TX_STREAM_ADAPTER_STATS_EN
   logic [31:0] stat_frames_r;
   logic [31:0] stat_stall_r;

   // Statistics counters; both wrap naturally at 2^32.
   always_ff @(posedge ap_clk or negedge rst_int_n_s) begin
      if (!rst_int_n_s) begin
         stat_frames_r <= 32'd0;
         stat_stall_r  <= 32'd0;
      end else begin
         if (resp_fire_s) begin
            stat_frames_r <= stat_frames_r + 32'd1;
         end else begin
            stat_frames_r <= stat_frames_r;
         end
         if (m_axis_out_tvalid && !m_axis_out_tready) begin
            stat_stall_r <= stat_stall_r + 32'd1;
         end else begin
            stat_stall_r <= stat_stall_r;
         end
      end
   end

   assign stat_frames       = stat_frames_r;
   assign stat_stall_cycles = stat_stall_r;
`endif

endmodule

// File: tb/tb_tx_stream_adapter.sv
// -----------------------------------------------------------------------------
// tb_tx_stream_adapter
//
// Directed testbench for tx_stream_adapter. Inputs change on the falling edge.
// Outputs are sampled 1 ns later, well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_tx_stream_adapter;

   logic        ap_clk;
   logic        ap_rst_n;
   logic [63:0] s_axis_tx_req_tdata;
   logic        s_axis_tx_req_tvalid;
   logic        s_axis_tx_req_tready;
   logic [31:0] s_axis_tx_data_tdata;
   logic        s_axis_tx_data_tvalid;
   logic        s_axis_tx_data_tready;
   logic [63:0] m_axis_tx_resp_tdata;
   logic        m_axis_tx_resp_tvalid;
   logic        m_axis_tx_resp_tready;
   logic [31:0] m_axis_out_tdata;
   logic [3:0]  m_axis_out_tkeep;
   logic        m_axis_out_tlast;
   logic        m_axis_out_tvalid;
   logic        m_axis_out_tready;
   logic        detect_fault;
`ifdef TX_STREAM_ADAPTER_STATS_EN
   logic [31:0] stat_frames;
   logic [31:0] stat_stall_cycles;
`endif

   int checks;
   int errors;

   tx_stream_adapter dut (
      .ap_clk                (ap_clk),
      .ap_rst_n              (ap_rst_n),
      .s_axis_tx_req_tdata   (s_axis_tx_req_tdata),
      .s_axis_tx_req_tvalid  (s_axis_tx_req_tvalid),
      .s_axis_tx_req_tready  (s_axis_tx_req_tready),
      .s_axis_tx_data_tdata  (s_axis_tx_data_tdata),
      .s_axis_tx_data_tvalid (s_axis_tx_data_tvalid),
      .s_axis_tx_data_tready (s_axis_tx_data_tready),
      .m_axis_tx_resp_tdata  (m_axis_tx_resp_tdata),
      .m_axis_tx_resp_tvalid (m_axis_tx_resp_tvalid),
      .m_axis_tx_resp_tready (m_axis_tx_resp_tready),
      .m_axis_out_tdata      (m_axis_out_tdata),
      .m_axis_out_tkeep      (m_axis_out_tkeep),
      .m_axis_out_tlast      (m_axis_out_tlast),
      .m_axis_out_tvalid     (m_axis_out_tvalid),
      .m_axis_out_tready     (m_axis_out_tready),
`ifdef TX_STREAM_ADAPTER_STATS_EN
      .stat_frames           (stat_frames),
      .stat_stall_cycles     (stat_stall_cycles),
`endif
      .detect_fault          (detect_fault)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   // Reset values, then the first cycles after reset is released.
   task automatic test_reset();
      ap_rst_n              = 1'b0;
      s_axis_tx_req_tdata   = 64'd0;
      s_axis_tx_req_tvalid  = 1'b0;
      s_axis_tx_data_tdata  = 32'd0;
      s_axis_tx_data_tvalid = 1'b0;
      m_axis_tx_resp_tready = 1'b0;
      m_axis_out_tready     = 1'b0;
      repeat (2) @(negedge ap_clk);
      #1;
      checks++; if (s_axis_tx_req_tready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b exp 0", s_axis_tx_req_tready); end
      checks++; if (m_axis_tx_resp_tvalid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", m_axis_tx_resp_tvalid); end
      checks++; if (m_axis_tx_resp_tdata !== 64'd0) begin errors++; $display("FAIL rst_resp_data got %h exp 0", m_axis_tx_resp_tdata); end
      checks++; if (m_axis_out_tvalid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", m_axis_out_tvalid); end
      checks++; if (detect_fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %b exp 0", detect_fault); end
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      // Two edges to release the internal reset, then one edge to register the ready.
      repeat (3) @(negedge ap_clk);
      #1;
      checks++; if (s_axis_tx_req_tready !== 1'b1) begin errors++; $display("FAIL post_rst_req_ready got %b exp 1", s_axis_tx_req_tready); end
      checks++; if (s_axis_tx_data_tready !== 1'b0) begin errors++; $display("FAIL post_rst_data_ready got %b exp 0", s_axis_tx_data_tready); end
   endtask

   // len=16, tag=A5: four full beats.
   task automatic test_full_words();
      logic [31:0] words [4];
      words = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 32'hDDEE_FF00};
      s_axis_tx_req_tdata  = {32'h0000_00A5, 32'd16};
      s_axis_tx_req_tvalid = 1'b1;
      #1;
      checks++; if (s_axis_tx_req_tready !== 1'b1) begin errors++; $display("FAIL t1_req_ready got %b exp 1", s_axis_tx_req_tready); end
      @(negedge ap_clk);
      s_axis_tx_req_tvalid = 1'b0;
      m_axis_out_tready    = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_axis_tx_data_tvalid = 1'b1;
         s_axis_tx_data_tdata  = words[i];
         #1;
         checks++; if (m_axis_out_tvalid !== 1'b1) begin errors++; $display("FAIL t1_out_valid beat %0d got %b exp 1", i, m_axis_out_tvalid); end
         checks++; if (m_axis_out_tdata !== words[i]) begin errors++; $display("FAIL t1_out_data beat %0d got %h exp %h", i, m_axis_out_tdata, words[i]); end
         checks++; if (m_axis_out_tkeep !== 4'hF) begin errors++; $display("FAIL t1_keep beat %0d got %h exp F", i, m_axis_out_tkeep); end
         checks++; if (m_axis_out_tlast !== (i == 3)) begin errors++; $display("FAIL t1_last beat %0d got %b exp %b", i, m_axis_out_tlast, (i == 3)); end
         @(negedge ap_clk);
      end
      s_axis_tx_data_tvalid = 1'b0;
      #1;
      checks++; if (m_axis_tx_resp_tvalid !== 1'b1) begin errors++; $display("FAIL t1_resp_valid got %b exp 1", m_axis_tx_resp_tvalid); end
      checks++; if (m_axis_tx_resp_tdata !== 64'h0000_00A5_0000_0010) begin errors++; $display("FAIL t1_resp_data got %h exp 00000a5_00000010", m_axis_tx_resp_tdata); end
      m_axis_tx_resp_tready = 1'b1;
      @(negedge ap_clk);
      m_axis_tx_resp_tready = 1'b0;
      #1;
      checks++; if (m_axis_tx_resp_tvalid !== 1'b0) begin errors++; $display("FAIL t1_resp_drop got %b exp 0", m_axis_tx_resp_tvalid); end
      checks++; if (s_axis_tx_req_tready !== 1'b1) begin errors++; $display("FAIL t1_idle_ready got %b exp 1", s_axis_tx_req_tready); end
   endtask

   // len=6: a full beat, then a two-byte tail.
   task automatic test_partial_tail();
      logic [3:0] keeps [2];
      keeps = '{4'hF, 4'h3};
      s_axis_tx_req_tdata  = {32'h0000_0002, 32'd6};
      s_axis_tx_req_tvalid = 1'b1;
      @(negedge ap_clk);
      s_axis_tx_req_tvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         s_axis_tx_data_tvalid = 1'b1;
         s_axis_tx_data_tdata  = 32'hC0DE_0000 + 32'(i);
         #1;
         checks++; if (m_axis_out_tkeep !== keeps[i]) begin errors++; $display("FAIL t2_keep beat %0d got %h exp %h", i, m_axis_out_tkeep, keeps[i]); end
         checks++; if (m_axis_out_tlast !== (i == 1)) begin errors++; $display("FAIL t2_last beat %0d got %b exp %b", i, m_axis_out_tlast, (i == 1)); end
         @(negedge ap_clk);
      end
      s_axis_tx_data_tvalid = 1'b0;
      #1;
      checks++; if (m_axis_tx_resp_tdata !== 64'h0000_0002_0000_0006) begin errors++; $display("FAIL t2_resp_data got %h exp 00000002_00000006", m_axis_tx_resp_tdata); end
      m_axis_tx_resp_tready = 1'b1;
      @(negedge ap_clk);
      m_axis_tx_resp_tready = 1'b0;
   endtask

   // len=0: straight to the response; payload offered meanwhile must not be taken.
   task automatic test_zero_length();
      s_axis_tx_req_tdata   = {32'h0000_0007, 32'd0};
      s_axis_tx_req_tvalid  = 1'b1;
      s_axis_tx_data_tvalid = 1'b1;
      s_axis_tx_data_tdata  = 32'hDEAD_BEEF;
      @(negedge ap_clk);
      s_axis_tx_req_tvalid = 1'b0;
      #1;
      checks++; if (m_axis_out_tvalid !== 1'b0) begin errors++; $display("FAIL t3_out_valid got %b exp 0", m_axis_out_tvalid); end
      checks++; if (s_axis_tx_data_tready !== 1'b0) begin errors++; $display("FAIL t3_data_ready got %b exp 0", s_axis_tx_data_tready); end
      checks++; if (m_axis_tx_resp_tvalid !== 1'b1) begin errors++; $display("FAIL t3_resp_valid got %b exp 1", m_axis_tx_resp_tvalid); end
      checks++; if (m_axis_tx_resp_tdata !== 64'h0000_0007_0000_0000) begin errors++; $display("FAIL t3_resp_data got %h exp 00000007_00000000", m_axis_tx_resp_tdata); end
      m_axis_tx_resp_tready = 1'b1;
      @(negedge ap_clk);
      m_axis_tx_resp_tready = 1'b0;
      s_axis_tx_data_tvalid = 1'b0;
   endtask

   // len=12 with output ready toggling 1-0-0-1-0-1.
   task automatic test_stall();
      logic [31:0] words [3];
      logic        pat [6];
      int          beat;
      words = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
      pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      beat  = 0;
      s_axis_tx_req_tdata  = {32'h0000_0044, 32'd12};
      s_axis_tx_req_tvalid = 1'b1;
      @(negedge ap_clk);
      s_axis_tx_req_tvalid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         m_axis_out_tready     = pat[c];
         s_axis_tx_data_tvalid = 1'b1;
         s_axis_tx_data_tdata  = words[beat];
         #1;
         checks++; if (m_axis_out_tvalid !== 1'b1) begin errors++; $display("FAIL t4_out_valid cyc %0d got %b exp 1", c, m_axis_out_tvalid); end
         checks++; if (m_axis_out_tdata !== words[beat]) begin errors++; $display("FAIL t4_out_data cyc %0d got %h exp %h", c, m_axis_out_tdata, words[beat]); end
         checks++; if (m_axis_out_tlast !== (beat == 2)) begin errors++; $display("FAIL t4_last cyc %0d got %b exp %b", c, m_axis_out_tlast, (beat == 2)); end
         checks++; if (s_axis_tx_data_tready !== pat[c]) begin errors++; $display("FAIL t4_data_ready cyc %0d got %b exp %b", c, s_axis_tx_data_tready, pat[c]); end
         @(negedge ap_clk);
         if (pat[c]) beat++;
      end
      s_axis_tx_data_tvalid = 1'b0;
      m_axis_out_tready     = 1'b1;
      #1;
      checks++; if (m_axis_tx_resp_tdata !== 64'h0000_0044_0000_000C) begin errors++; $display("FAIL t4_resp_data got %h exp 00000044_0000000c", m_axis_tx_resp_tdata); end
`ifdef TX_STREAM_ADAPTER_STATS_EN
      checks++; if (stat_stall_cycles !== 32'd3) begin errors++; $display("FAIL t4_stall_cnt got %0d exp 3", stat_stall_cycles); end
      checks++; if (stat_frames !== 32'd3) begin errors++; $display("FAIL t4_frame_cnt got %0d exp 3", stat_frames); end
`endif
      m_axis_tx_resp_tready = 1'b1;
      @(negedge ap_clk);
      m_axis_tx_resp_tready = 1'b0;
   endtask

   // Response held back for 5 cycles while a second request waits.
   task automatic test_back_to_back();
      s_axis_tx_req_tdata  = {32'h0000_0009, 32'd4};
      s_axis_tx_req_tvalid = 1'b1;
      @(negedge ap_clk);
      s_axis_tx_req_tdata   = {32'h0000_0011, 32'd4};
      s_axis_tx_data_tvalid = 1'b1;
      s_axis_tx_data_tdata  = 32'h1234_5678;
      @(negedge ap_clk);
      s_axis_tx_data_tvalid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++; if (m_axis_tx_resp_tvalid !== 1'b1) begin errors++; $display("FAIL t5_resp_hold cyc %0d got %b exp 1", c, m_axis_tx_resp_tvalid); end
         checks++; if (m_axis_tx_resp_tdata !== 64'h0000_0009_0000_0004) begin errors++; $display("FAIL t5_resp_stable cyc %0d got %h exp 00000009_00000004", c, m_axis_tx_resp_tdata); end
         checks++; if (s_axis_tx_req_tready !== 1'b0) begin errors++; $display("FAIL t5_req_blocked cyc %0d got %b exp 0", c, s_axis_tx_req_tready); end
         @(negedge ap_clk);
      end
      m_axis_tx_resp_tready = 1'b1;
      #1;
      checks++; if (s_axis_tx_req_tready !== 1'b0) begin errors++; $display("FAIL t5_req_at_hs got %b exp 0", s_axis_tx_req_tready); end
      @(negedge ap_clk);
      m_axis_tx_resp_tready = 1'b0;
      #1;
      checks++; if (s_axis_tx_req_tready !== 1'b1) begin errors++; $display("FAIL t5_req_after_hs got %b exp 1", s_axis_tx_req_tready); end
      @(negedge ap_clk);
      s_axis_tx_req_tvalid  = 1'b0;
      s_axis_tx_data_tvalid = 1'b1;
      s_axis_tx_data_tdata  = 32'h8765_4321;
      #1;
      checks++; if (m_axis_out_tlast !== 1'b1) begin errors++; $display("FAIL t5_2nd_last got %b exp 1", m_axis_out_tlast); end
      checks++; if (m_axis_out_tdata !== 32'h8765_4321) begin errors++; $display("FAIL t5_2nd_data got %h exp 87654321", m_axis_out_tdata); end
      @(negedge ap_clk);
      s_axis_tx_data_tvalid = 1'b0;
      #1;
      checks++; if (m_axis_tx_resp_tdata !== 64'h0000_0011_0000_0004) begin errors++; $display("FAIL t5_2nd_resp got %h exp 00000011_00000004", m_axis_tx_resp_tdata); end
      m_axis_tx_resp_tready = 1'b1;
      @(negedge ap_clk);
      m_axis_tx_resp_tready = 1'b0;
   endtask

   // Over-length request sets the fault; a reset mid-frame abandons the frame.
   task automatic test_fault_and_reset();
      #1;
      checks++; if (detect_fault !== 1'b0) begin errors++; $display("FAIL t6_fault_before got %b exp 0", detect_fault); end
      s_axis_tx_req_tdata  = {32'h0000_0033, 32'h0100_0001};
      s_axis_tx_req_tvalid = 1'b1;
      @(negedge ap_clk);
      s_axis_tx_req_tvalid = 1'b0;
      #1;
      checks++; if (detect_fault !== 1'b1) begin errors++; $display("FAIL t6_fault_set got %b exp 1", detect_fault); end
      for (int i = 0; i < 2; i++) begin
         s_axis_tx_data_tvalid = 1'b1;
         s_axis_tx_data_tdata  = 32'hF00D_0000 + 32'(i);
         #1;
         checks++; if (m_axis_out_tkeep !== 4'hF || m_axis_out_tlast !== 1'b0) begin errors++; $display("FAIL t6_mid_beat %0d got keep %h last %b exp F 0", i, m_axis_out_tkeep, m_axis_out_tlast); end
         @(negedge ap_clk);
      end
      ap_rst_n = 1'b0;
      #1;
      checks++; if (m_axis_out_tvalid !== 1'b0) begin errors++; $display("FAIL t6_rst_out_valid got %b exp 0", m_axis_out_tvalid); end
      checks++; if (s_axis_tx_data_tready !== 1'b0) begin errors++; $display("FAIL t6_rst_data_ready got %b exp 0", s_axis_tx_data_tready); end
      checks++; if (m_axis_tx_resp_tvalid !== 1'b0) begin errors++; $display("FAIL t6_rst_resp_valid got %b exp 0", m_axis_tx_resp_tvalid); end
      checks++; if (detect_fault !== 1'b0) begin errors++; $display("FAIL t6_rst_fault got %b exp 0", detect_fault); end
      s_axis_tx_data_tvalid = 1'b0;
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      repeat (3) @(negedge ap_clk);
      #1;
      checks++; if (s_axis_tx_req_tready !== 1'b1) begin errors++; $display("FAIL t6_idle_ready got %b exp 1", s_axis_tx_req_tready); end
`ifdef TX_STREAM_ADAPTER_STATS_EN
      checks++; if (stat_frames !== 32'd0) begin errors++; $display("FAIL t6_frames_cleared got %0d exp 0", stat_frames); end
`endif
      // A fresh three-byte frame proves the block restarted cleanly.
      s_axis_tx_req_tdata  = {32'h0000_0055, 32'd3};
      s_axis_tx_req_tvalid = 1'b1;
      @(negedge ap_clk);
      s_axis_tx_req_tvalid  = 1'b0;
      s_axis_tx_data_tvalid = 1'b1;
      s_axis_tx_data_tdata  = 32'hAABB_CCDD;
      #1;
      checks++; if (m_axis_out_tkeep !== 4'h7) begin errors++; $display("FAIL t6_keep3 got %h exp 7", m_axis_out_tkeep); end
      checks++; if (m_axis_out_tlast !== 1'b1) begin errors++; $display("FAIL t6_last3 got %b exp 1", m_axis_out_tlast); end
      @(negedge ap_clk);
      s_axis_tx_data_tvalid = 1'b0;
      #1;
      checks++; if (m_axis_tx_resp_tdata !== 64'h0000_0055_0000_0003) begin errors++; $display("FAIL t6_resp3 got %h exp 00000055_00000003", m_axis_tx_resp_tdata); end
      checks++; if (detect_fault !== 1'b0) begin errors++; $display("FAIL t6_fault_clear got %b exp 0", detect_fault); end
      m_axis_tx_resp_tready = 1'b1;
      @(negedge ap_clk);
      m_axis_tx_resp_tready = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_full_words();
      test_partial_tail();
      test_zero_length();
      test_stall();
      test_back_to_back();
      test_fault_and_reset();
      repeat (2) @(negedge ap_clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
